// File: rtl/sys_reg_file.sv
// sys_reg_file: flop-based register file behind the system controller.
// Optional build macro REGF_CFG_LOCK_EN: once address 3 has been written after reset,
// addresses 2 and 3 become write-protected until the next RST.
// Ports:
//   CLK, RST                 clock (rising edge) and async active-low reset
//   WrEn, RdEn               write/read strobes; both high together is a no-op
//   Address, WrData          register index and write data
//   RdData, RdData_Valid     read data registered one cycle after RdEn, with a one-cycle valid
//   REG0..REG3               live views of registers 0..3 (ALU A, ALU B, UART cfg, clock div)
module sys_reg_file #(
    parameter int D_WIDTH = 8,
    parameter int DEPTH   = 16,
    parameter int ADDRESS = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WrEn,
    input  logic               RdEn,
    input  logic [ADDRESS-1:0] Address,
    input  logic [D_WIDTH-1:0] WrData,
    output logic [D_WIDTH-1:0] RdData,
    output logic               RdData_Valid,
    output logic [D_WIDTH-1:0] REG0,
    output logic [D_WIDTH-1:0] REG1,
    output logic [D_WIDTH-1:0] REG2,
    output logic [D_WIDTH-1:0] REG3
);
    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [D_WIDTH-1:0] mem_d [DEPTH];
    logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               in_range, rd, wr, blocked;

`ifdef REGF_CFG_LOCK_EN
    logic lock_q, lock_d;
    always_comb begin
        blocked = lock_q && (Address == ADDRESS'(2) || Address == ADDRESS'(3));
        lock_d  = lock_q || (wr && Address == ADDRESS'(3));
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) lock_q <= 1'b0;
        else      lock_q <= lock_d;
    end
`else
    assign blocked = 1'b0;
`endif

    always_comb begin
        in_range   = 32'(Address) < DEPTH;
        rd         = RdEn && !WrEn;
        wr         = WrEn && !RdEn && in_range && !blocked;
        mem_d      = mem_q;
        if (wr) mem_d[Address] = WrData;
        // out-of-range reads still pulse valid so the controller never waits
        rd_data_d  = rd ? (in_range ? mem_q[Address] : '0) : rd_data_q;
        rd_valid_d = rd;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            mem_q[2]   <= D_WIDTH'(8'h81);
            mem_q[3]   <= D_WIDTH'(8'h20);
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign RdData       = rd_data_q;
    assign RdData_Valid = rd_valid_q;
    assign REG0         = mem_q[0];
    assign REG1         = mem_q[1];
    assign REG2         = mem_q[2];
    assign REG3         = mem_q[3];
endmodule

// File: tb/tb_sys_reg_file.sv
// tb_sys_reg_file: scoreboard bench for sys_reg_file with directed vectors.
module tb_sys_reg_file;
    logic       CLK = 1'b0, RST = 1'b0, WrEn = 1'b0, RdEn = 1'b0;
    logic [3:0] Address = '0;
    logic [7:0] WrData = '0;
    logic [7:0] RdData, REG0, REG1, REG2, REG3;
    logic       RdData_Valid;
    int         checks = 0, failures = 0;
    logic [7:0] exp_q [$];

    sys_reg_file dut (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .REG0(REG0), .REG1(REG1), .REG2(REG2), .REG3(REG3)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST && RdData_Valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%h required=no_pulse", RdData);
            end else begin
                check("rd_data", RdData, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic we, input logic re, input logic [3:0] a, input logic [7:0] d);
        WrEn = we; RdEn = re; Address = a; WrData = d;
        @(posedge CLK); #1;
        WrEn = 1'b0; RdEn = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        cyc(1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        idle(1);
        check("rst_reg0", REG0, 8'h00);
        check("rst_reg1", REG1, 8'h00);
        check("rst_reg2", REG2, 8'h81);
        check("rst_reg3", REG3, 8'h20);
        check("rst_rddata", RdData, 8'h00);
        check("rst_valid", {7'd0, RdData_Valid}, 8'h00);
        rd(4'd2, 8'h81);
        rd(4'd3, 8'h20);
        idle(2);
        wr(4'd5, 8'hA5);
        check("wr_keeps_rddata", RdData, 8'h20);
        rd(4'd5, 8'hA5);
        idle(1);
        check("valid_drops", {7'd0, RdData_Valid}, 8'h00);
        check("rddata_holds", RdData, 8'hA5);
        wr(4'd0, 8'h12);
        check("reg0_after_wr", REG0, 8'h12);
        wr(4'd1, 8'h34);
        check("reg1_after_wr", REG1, 8'h34);
        rd(4'd0, 8'h12);
        rd(4'd1, 8'h34);
        rd(4'd0, 8'h12);
        idle(2);
        cyc(1'b1, 1'b1, 4'd7, 8'hFF);
        check("conflict_valid", {7'd0, RdData_Valid}, 8'h00);
        check("conflict_rddata_holds", RdData, 8'h12);
        rd(4'd7, 8'h00);
        idle(2);
        wr(4'd3, 8'h08);
        wr(4'd3, 8'h10);
        wr(4'd2, 8'h00);
`ifdef REGF_CFG_LOCK_EN
        check("lock_reg3", REG3, 8'h08);
        check("lock_reg2", REG2, 8'h81);
        rd(4'd3, 8'h08);
`else
        check("nolock_reg3", REG3, 8'h10);
        check("nolock_reg2", REG2, 8'h00);
        rd(4'd3, 8'h10);
`endif
        idle(2);
        WrEn = 1'b0; RdEn = 1'b1; Address = 4'd1;
        @(posedge CLK);
        #1 RST = 1'b0; RdEn = 1'b0;
        #1;
        check("midrst_valid", {7'd0, RdData_Valid}, 8'h00);
        check("midrst_rddata", RdData, 8'h00);
        check("midrst_reg0", REG0, 8'h00);
        check("midrst_reg1", REG1, 8'h00);
        check("midrst_reg2", REG2, 8'h81);
        check("midrst_reg3", REG3, 8'h20);
        @(posedge CLK);
        #1 RST = 1'b1;
        idle(1);
        check("post_rst_valid", {7'd0, RdData_Valid}, 8'h00);
        wr(4'd3, 8'h44);
        check("reg3_after_rst_wr", REG3, 8'h44);
        rd(4'd3, 8'h44);
        idle(3);
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
